// File: rtl/echo_event_rx_if.sv
// Event hand-off bus from echo_event_rx to the voice allocator.
// Master drives the FIFO head and valid; slave returns ready.
interface echo_event_rx_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_type;
    logic [6:0] ev_note;
    logic [3:0] ev_vel;
    logic [8:0] ev_pb;

    modport master (
        output ev_valid, ev_type, ev_note, ev_vel, ev_pb,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_type, ev_note, ev_vel, ev_pb,
        output ev_ready
    );
endinterface

// File: rtl/echo_event_rx.sv
// Turns level-held echo note state into queued note-on/off (and optional pitch-bend) events.
// Optional feature: define ECHO_PB_EVENTS_EN to emit type 10 events on pb-only changes.
module echo_event_rx #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    echo_on_i,
    input  logic [6:0]              echo_note_i,
    input  logic [3:0]              echo_vel_i,
    input  logic [8:0]              echo_pb_i,
    echo_event_rx_if.master         ev_if,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    ovf_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [1:0] EV_OFF = 2'b00;
    localparam logic [1:0] EV_ON  = 2'b01;
`ifdef ECHO_PB_EVENTS_EN
    localparam logic [1:0] EV_PB  = 2'b10;
`endif

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [3:0] vel;
        logic [8:0] pb;
    } echo_state_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [6:0] note;
        logic [3:0] vel;
        logic [8:0] pb;
    } event_t;

    echo_state_t   s_q, s_d, prev_q, prev_d;
    event_t        mem_q [DEPTH];
    event_t        ev_c, head_c;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          has_ev_c, diff_c, push_c, pop_c, full_c, accept_c;

    // Classify the registered state against the last accepted state, in priority order
    always_comb begin
        ev_c     = '0;
        has_ev_c = 1'b0;
        if (!s_q.on && prev_q.on) begin
            has_ev_c   = 1'b1;
            ev_c.kind  = EV_OFF;
            ev_c.note  = s_q.note;
            ev_c.pb    = s_q.pb;
        end else if (s_q.on && (!prev_q.on || s_q.note != prev_q.note || s_q.vel != prev_q.vel)) begin
            has_ev_c   = 1'b1;
            ev_c.kind  = (s_q.vel == 4'd0) ? EV_OFF : EV_ON;
            ev_c.note  = s_q.note;
            ev_c.vel   = s_q.vel;
            ev_c.pb    = s_q.pb;
`ifdef ECHO_PB_EVENTS_EN
        end else if (s_q.on && s_q.pb != prev_q.pb) begin
            has_ev_c   = 1'b1;
            ev_c.kind  = EV_PB;
            ev_c.note  = s_q.note;
            ev_c.vel   = s_q.vel;
            ev_c.pb    = s_q.pb;
`endif
        end
    end

    // Next-state for capture, detection and FIFO bookkeeping
    always_comb begin
        diff_c   = (s_q != prev_q);
        push_c   = en_i && diff_c && has_ev_c;
        pop_c    = (level_q != '0) && ev_if.ev_ready;
        full_c   = (level_q == LW'(DEPTH));
        accept_c = push_c && (!full_c || pop_c);

        s_d      = en_i ? {echo_on_i, echo_note_i, echo_vel_i, echo_pb_i} : s_q;
        prev_d   = (en_i && diff_c) ? s_q : prev_q;
        wr_ptr_d = accept_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(accept_c) - LW'(pop_c);
        ovf_d    = ovf_q | (push_c && full_c && !pop_c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q      <= '0;
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s_q      <= s_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is cleared on reset so the head reads as all-zero when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (accept_c) begin
            mem_q[wr_ptr_q] <= ev_c;
        end
    end

    assign head_c         = mem_q[rd_ptr_q];
    assign ev_if.ev_valid = (level_q != '0);
    assign ev_if.ev_type  = head_c.kind;
    assign ev_if.ev_note  = head_c.note;
    assign ev_if.ev_vel   = head_c.vel;
    assign ev_if.ev_pb    = head_c.pb;
    assign level_o        = level_q;
    assign ovf_o          = ovf_q;
endmodule

// File: tb/tb_echo_event_rx.sv
// Randomized and directed bench for echo_event_rx against a queue-based event model.
// Pitch-bend expectations follow the ECHO_PB_EVENTS_EN macro.
module tb_echo_event_rx;
    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       echo_on;
    logic [6:0] echo_note;
    logic [3:0] echo_vel;
    logic [8:0] echo_pb;
    logic [$clog2(DEPTH):0] level;
    logic       ovf;

    echo_event_rx_if ev_if ();

    echo_event_rx #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en),
        .echo_on_i   (echo_on),
        .echo_note_i (echo_note),
        .echo_vel_i  (echo_vel),
        .echo_pb_i   (echo_pb),
        .ev_if       (ev_if),
        .level_o     (level),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       on;
        int       note;
        int       vel;
        int       pb;
    } mstate_t;

    typedef struct {
        int t;
        int note;
        int vel;
        int pb;
    } mev_t;

    mev_t    q[$];
    mstate_t m_s, m_prev;
    bit      m_ovf;
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit same_state(input mstate_t a, input mstate_t b);
        return a.on == b.on && a.note == b.note && a.vel == b.vel && a.pb == b.pb;
    endfunction

    // Event the allocator should see when the captured state moves from p to s
    function automatic bit classify(input mstate_t s, input mstate_t p, output mev_t e);
        e = '{0, 0, 0, 0};
        if (p.on && !s.on) begin
            e = '{0, s.note, 0, s.pb};
            return 1'b1;
        end
        if (s.on && (!p.on || s.note != p.note || s.vel != p.vel)) begin
            e = '{(s.vel == 0) ? 0 : 1, s.note, s.vel, s.pb};
            return 1'b1;
        end
`ifdef ECHO_PB_EVENTS_EN
        if (s.on && s.pb != p.pb) begin
            e = '{2, s.note, s.vel, s.pb};
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_s    = '{0, 0, 0, 0};
        m_prev = '{0, 0, 0, 0};
        m_ovf  = 1'b0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs
    task automatic model_edge();
        bit   do_pop;
        bit   has;
        mev_t e;
        do_pop = (q.size() != 0) && ev_if.ev_ready;
        if (en && !same_state(m_s, m_prev)) begin
            has    = classify(m_s, m_prev, e);
            m_prev = m_s;
            if (has) begin
                if (q.size() < int'(DEPTH) || do_pop) begin
                    if (do_pop) begin
                        void'(q.pop_front());
                        do_pop = 1'b0;
                    end
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (do_pop) void'(q.pop_front());
        if (en) m_s = '{echo_on, int'(echo_note), int'(echo_vel), int'(echo_pb)};
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".valid"}, 32'(ev_if.ev_valid), (q.size() != 0) ? 1 : 0);
        check_eq({tag, ".level"}, 32'(level), q.size());
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        if (q.size() != 0) begin
            check_eq({tag, ".type"}, 32'(ev_if.ev_type), q[0].t);
            check_eq({tag, ".note"}, 32'(ev_if.ev_note), q[0].note);
            check_eq({tag, ".vel"},  32'(ev_if.ev_vel),  q[0].vel);
            check_eq({tag, ".pb"},   32'(ev_if.ev_pb),   q[0].pb);
        end
    endtask

    // Drive inputs at a falling edge, advance one cycle, then compare against the model
    task automatic step(input string tag, input bit on, input int note, input int vel,
                        input int pb, input bit e, input bit rdy);
        echo_on        = on;
        echo_note      = 7'(note);
        echo_vel       = 4'(vel);
        echo_pb        = 9'(pb);
        en             = e;
        ev_if.ev_ready = rdy;
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, ".valid"}, 32'(ev_if.ev_valid), 0);
        check_eq({tag, ".level"}, 32'(level), 0);
        check_eq({tag, ".ovf"}, 32'(ovf), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0; echo_on = 1'b0; echo_note = '0; echo_vel = '0; echo_pb = '0;
        ev_if.ev_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.valid", 32'(ev_if.ev_valid), 0);
        check_eq("rst.type",  32'(ev_if.ev_type), 0);
        check_eq("rst.note",  32'(ev_if.ev_note), 0);
        check_eq("rst.vel",   32'(ev_if.ev_vel), 0);
        check_eq("rst.pb",    32'(ev_if.ev_pb), 0);
        check_eq("rst.level", 32'(level), 0);
        check_eq("rst.ovf",   32'(ovf), 0);
        reset = 1'b0;

        // Note-on latency: registered at first edge, visible after second
        step("on1", 1'b1, 60, 9, 256, 1'b1, 1'b0);
        check_eq("on1.valid", 32'(ev_if.ev_valid), 0);
        step("on2", 1'b1, 60, 9, 256, 1'b1, 1'b0);
        check_eq("on2.type", 32'(ev_if.ev_type), 1);
        check_eq("on2.note", 32'(ev_if.ev_note), 60);
        check_eq("on2.vel",  32'(ev_if.ev_vel), 9);
        check_eq("on2.pb",   32'(ev_if.ev_pb), 256);
        check_eq("on2.level", 32'(level), 1);

        // Note-off while draining
        step("off1", 1'b0, 60, 9, 256, 1'b1, 1'b1);
        step("off2", 1'b0, 60, 9, 256, 1'b1, 1'b1);
        check_eq("off2.type", 32'(ev_if.ev_type), 0);
        check_eq("off2.note", 32'(ev_if.ev_note), 60);
        check_eq("off2.vel",  32'(ev_if.ev_vel), 0);
        step("off3", 1'b0, 60, 9, 256, 1'b1, 1'b1);
        check_eq("drain.level", 32'(level), 0);

        // Overflow: DEPTH+2 alternating changes with the consumer stalled
        for (int i = 0; i < int'(DEPTH) + 2; i++)
            step("ovf_fill", (i % 2) == 0, 70, 5, 256, 1'b1, 1'b0);
        step("ovf_last", 1'b0, 70, 5, 256, 1'b1, 1'b0);
        check_eq("ovf.level", 32'(level), DEPTH);
        check_eq("ovf.flag", 32'(ovf), 1);
        for (int k = 0; k < int'(DEPTH); k++) begin
            check_eq("ovf.order", 32'(ev_if.ev_type), ((k % 2) == 0) ? 1 : 0);
            step("ovf_read", 1'b0, 70, 5, 256, 1'b1, 1'b1);
        end
        check_eq("ovf.empty", 32'(level), 0);

        // Pitch-bend-only change on a held note
        for (int i = 0; i < 3; i++) step("pb_setup", 1'b1, 64, 7, 256, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("pb_chg", 1'b1, 64, 7, 300, 1'b1, 1'b0);
`ifdef ECHO_PB_EVENTS_EN
        check_eq("pb.level", 32'(level), 1);
        check_eq("pb.type", 32'(ev_if.ev_type), 2);
        check_eq("pb.note", 32'(ev_if.ev_note), 64);
        check_eq("pb.pb", 32'(ev_if.ev_pb), 300);
`else
        check_eq("pb.level", 32'(level), 0);
`endif
        step("pb_drain", 1'b1, 64, 7, 300, 1'b1, 1'b1);

        // Full FIFO with simultaneous push and pop
        pulse_reset("rst_a");
        for (int i = 0; i < int'(DEPTH) + 1; i++)
            step("full_fill", (i % 2) == 0, 70, 5, 256, 1'b1, 1'b0);
        check_eq("full.level", 32'(level), DEPTH);
        step("full_pp", (DEPTH % 2) == 0, 70, 5, 256, 1'b1, 1'b1);
        check_eq("full_pp.level", 32'(level), DEPTH);
        check_eq("full_pp.ovf", 32'(ovf), 0);
        pulse_reset("rst_b");

        // Randomized traffic, including enable gaps and consumer stalls
        for (int n = 0; n < 600; n++) begin
            bit nb_on;
            int nb_note, nb_vel, nb_pb;
            nb_on   = echo_on;
            nb_note = int'(echo_note);
            nb_vel  = int'(echo_vel);
            nb_pb   = int'(echo_pb);
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 3))
                    0: nb_on   = ~nb_on;
                    1: nb_note = ($urandom_range(0, 1) != 0) ? 60 : 61;
                    2: nb_vel  = ($urandom_range(0, 2) == 0) ? 0 : 5;
                    default: nb_pb = ($urandom_range(0, 1) != 0) ? 256 : 300;
                endcase
            end
            step("rand", nb_on, nb_note, nb_vel, nb_pb,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4);
        end
        check_eq("rand.nonzero_ovf_model_sync", 32'(ovf), 32'(m_ovf));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
